sd_read_sequencer: RTL and testbench

SD_READ_SEQUENCER -- requirements
Module: sd_read_sequencer

---
 rtl/sd_pkg.sv | 17 +
 rtl/edge_detect.sv | 22 ++
 rtl/sd_read_sequencer.sv | 210 +++++++++++++++++++++
 tb/tb_sd_read_sequencer.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sd_pkg.sv
// Shared definitions for the SD sector read sequencer: FSM state encoding and
// default sizing constants.
package sd_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT_READY,
    ST_ISSUE,
    ST_READ,
    ST_FINISH
  } sd_state_t;

  localparam int SD_SECTOR_BYTES   = 512;
  // 100 ms at 25 MHz
  localparam int SD_TIMEOUT_CYCLES = 2_500_000;

endpackage

// File: rtl/edge_detect.sv
// Rising-edge detector: registers the previous level and flags a low-to-high
// change in the cycle where the new level is first sampled.
module edge_detect (
  input  logic clk_in,
  input  logic rst_in,
  input  logic level_in,
  output logic rise_out
);

  logic level_reg;

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      level_reg <= 1'b0;
    end else begin
      level_reg <= level_in;
    end
  end

  assign rise_out = level_in & ~level_reg;

endmodule

// File: rtl/sd_read_sequencer.sv
// Multi-sector read sequencer in front of an sd_controller: issues one read per
// sector, streams the bytes out with position tags, and guards every handshake
// phase with a timeout.
module sd_read_sequencer
  import sd_pkg::*;
#(
  parameter int SECTOR_BYTES   = SD_SECTOR_BYTES,
  parameter int TIMEOUT_CYCLES = SD_TIMEOUT_CYCLES,
  parameter bit BYTE_ADDR      = 1'b1
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        start_in,
  input  logic [31:0] start_sector_in,
  input  logic [15:0] num_sectors_in,
  input  logic        abort_in,
  input  logic        sd_ready_in,
  input  logic        sd_byte_available_in,
  input  logic [7:0]  sd_dout_in,
  output logic        sd_rd_out,
  output logic [31:0] sd_addr_out,
  output logic [7:0]  data_out,
  output logic        data_valid_out,
  output logic [8:0]  byte_index_out,
  output logic [15:0] sector_index_out,
  output logic        busy_out,
  output logic        done_out,
  output logic        error_out
);

  localparam int                 TIMER_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT_CYCLES - 1);
  localparam logic [8:0]         BYTE_LAST  = 9'(SECTOR_BYTES - 1);

  sd_state_t          state_reg;
  logic [31:0]        start_sector_reg;
  logic [15:0]        num_sectors_reg;
  logic [15:0]        sector_cnt_reg;
  logic [8:0]         byte_cnt_reg;
  logic [TIMER_W-1:0] timer_reg;
  logic               abort_reg;
  logic               rd_reg;
  logic [31:0]        addr_reg;
  logic [7:0]         data_reg;
  logic               valid_reg;
  logic [8:0]         byte_index_reg;
  logic [15:0]        sector_index_reg;
  logic               busy_reg;
  logic               done_reg;
  logic               error_reg;

  logic        byte_rise;
  logic [31:0] sector_num;
  logic [31:0] issue_addr;
  logic        timed_out;
  logic        last_sector;
  logic        abort_seen;

  edge_detect u_byte_edge (
    .clk_in   (clk_in),
    .rst_in   (rst_in),
    .level_in (sd_byte_available_in),
    .rise_out (byte_rise)
  );

  assign sector_num = start_sector_reg + 32'(sector_cnt_reg);

  generate
    if (BYTE_ADDR) begin : g_byte_addr
      assign issue_addr = sector_num * 32'(SECTOR_BYTES);
    end else begin : g_sector_addr
      assign issue_addr = sector_num;
    end
  endgenerate

  assign timed_out   = (timer_reg == TIMER_LAST);
  assign last_sector = ((sector_cnt_reg + 16'd1) == num_sectors_reg);
  // An abort arriving in the same cycle as a decision point counts as latched.
  assign abort_seen  = abort_reg | abort_in;

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_reg        <= ST_IDLE;
      start_sector_reg <= '0;
      num_sectors_reg  <= '0;
      sector_cnt_reg   <= '0;
      byte_cnt_reg     <= '0;
      timer_reg        <= '0;
      abort_reg        <= 1'b0;
      rd_reg           <= 1'b0;
      addr_reg         <= '0;
      data_reg         <= '0;
      valid_reg        <= 1'b0;
      byte_index_reg   <= '0;
      sector_index_reg <= '0;
      busy_reg         <= 1'b0;
      done_reg         <= 1'b0;
      error_reg        <= 1'b0;
    end else begin
      valid_reg <= 1'b0;
      done_reg  <= 1'b0;
      timer_reg <= timer_reg + TIMER_W'(1);
      if (state_reg != ST_IDLE && abort_in) begin
        abort_reg <= 1'b1;
      end

      unique case (state_reg)
        ST_IDLE: begin
          timer_reg <= '0;
          if (start_in) begin
            if (num_sectors_in != 16'd0) begin
              start_sector_reg <= start_sector_in;
              num_sectors_reg  <= num_sectors_in;
              sector_cnt_reg   <= '0;
              byte_cnt_reg     <= '0;
              abort_reg        <= 1'b0;
              error_reg        <= 1'b0;
              busy_reg         <= 1'b1;
              state_reg        <= ST_WAIT_READY;
            end else begin
              done_reg <= 1'b1;
            end
          end
        end

        ST_WAIT_READY: begin
          if (abort_seen) begin
            state_reg <= ST_FINISH;
            done_reg  <= 1'b1;
            timer_reg <= '0;
          end else if (sd_ready_in) begin
            rd_reg    <= 1'b1;
            addr_reg  <= issue_addr;
            state_reg <= ST_ISSUE;
            timer_reg <= '0;
          end else if (timed_out) begin
            error_reg <= 1'b1;
            state_reg <= ST_FINISH;
            done_reg  <= 1'b1;
            timer_reg <= '0;
          end
        end

        ST_ISSUE: begin
          // The controller drops ready once it has taken the request.
          if (!sd_ready_in) begin
            rd_reg    <= 1'b0;
            state_reg <= ST_READ;
            timer_reg <= '0;
          end else if (timed_out) begin
            rd_reg    <= 1'b0;
            error_reg <= 1'b1;
            state_reg <= ST_FINISH;
            done_reg  <= 1'b1;
            timer_reg <= '0;
          end
        end

        ST_READ: begin
          if (byte_rise) begin
            data_reg         <= sd_dout_in;
            valid_reg        <= 1'b1;
            byte_index_reg   <= byte_cnt_reg;
            sector_index_reg <= sector_cnt_reg;
            timer_reg        <= '0;
            if (byte_cnt_reg == BYTE_LAST) begin
              byte_cnt_reg   <= '0;
              sector_cnt_reg <= sector_cnt_reg + 16'd1;
              if (last_sector || abort_seen) begin
                state_reg <= ST_FINISH;
                done_reg  <= 1'b1;
              end else begin
                state_reg <= ST_WAIT_READY;
              end
            end else begin
              byte_cnt_reg <= byte_cnt_reg + 9'd1;
            end
          end else if (timed_out) begin
            error_reg <= 1'b1;
            state_reg <= ST_FINISH;
            done_reg  <= 1'b1;
            timer_reg <= '0;
          end
        end

        ST_FINISH: begin
          // done_out is high for exactly this state's cycle; busy ends with it.
          busy_reg  <= 1'b0;
          state_reg <= ST_IDLE;
          timer_reg <= '0;
        end

        default: begin
          state_reg <= ST_IDLE;
        end
      endcase
    end
  end

  assign sd_rd_out        = rd_reg;
  assign sd_addr_out      = addr_reg;
  assign data_out         = data_reg;
  assign data_valid_out   = valid_reg;
  assign byte_index_out   = byte_index_reg;
  assign sector_index_out = sector_index_reg;
  assign busy_out         = busy_reg;
  assign done_out         = done_reg;
  assign error_out        = error_reg;

endmodule

// File: tb/tb_sd_read_sequencer.sv
// Randomized bench for sd_read_sequencer: a behavioural SD card model feeds
// random bytes, a scoreboard checks the stream, addresses and run outcomes.
module tb_sd_read_sequencer;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic        start_in;
  logic [31:0] start_sector_in;
  logic [15:0] num_sectors_in;
  logic        abort_in;
  logic        sd_ready_in;
  logic        sd_byte_available_in;
  logic [7:0]  sd_dout_in;
  logic        sd_rd_out;
  logic [31:0] sd_addr_out;
  logic [7:0]  data_out;
  logic        data_valid_out;
  logic [8:0]  byte_index_out;
  logic [15:0] sector_index_out;
  logic        busy_out;
  logic        done_out;
  logic        error_out;

  always #20 clk_in = ~clk_in;

  sd_read_sequencer #(
    .SECTOR_BYTES   (512),
    .TIMEOUT_CYCLES (50),
    .BYTE_ADDR      (1'b1)
  ) dut (
    .clk_in               (clk_in),
    .rst_in               (rst_in),
    .start_in             (start_in),
    .start_sector_in      (start_sector_in),
    .num_sectors_in       (num_sectors_in),
    .abort_in             (abort_in),
    .sd_ready_in          (sd_ready_in),
    .sd_byte_available_in (sd_byte_available_in),
    .sd_dout_in           (sd_dout_in),
    .sd_rd_out            (sd_rd_out),
    .sd_addr_out          (sd_addr_out),
    .data_out             (data_out),
    .data_valid_out       (data_valid_out),
    .byte_index_out       (byte_index_out),
    .sector_index_out     (sector_index_out),
    .busy_out             (busy_out),
    .done_out             (done_out),
    .error_out            (error_out)
  );

  int check_cnt = 0;
  int pass_cnt  = 0;

  logic [7:0]  sb[$];
  logic [31:0] got_addr[$];
  int valid_cnt = 0;
  int done_cnt  = 0;
  int rd_cnt    = 0;
  bit expect_valid = 1'b1;
  bit ready_stuck  = 1'b0;
  bit hold4        = 1'b0;
  bit model_active = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    check_cnt++;
    if (got === exp) begin
      pass_cnt++;
    end else begin
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // SD card model: serves each read with one sector of random bytes, then emits
  // a stray byte strobe while the sequencer is not reading.
  initial begin
    logic [7:0] byte_v;
    sd_ready_in          = 1'b1;
    sd_byte_available_in = 1'b0;
    sd_dout_in           = 8'h00;
    forever begin
      @(negedge clk_in);
      sd_ready_in = !ready_stuck;
      if (sd_rd_out && !ready_stuck) begin
        model_active = 1'b1;
        got_addr.push_back(sd_addr_out);
        repeat ($urandom_range(1, 5)) @(negedge clk_in);
        sd_ready_in = 1'b0;
        @(negedge clk_in);
        for (int b = 0; b < 512; b++) begin
          byte_v = 8'($urandom);
          sd_dout_in = byte_v;
          sd_byte_available_in = 1'b1;
          sb.push_back(byte_v);
          repeat (hold4 ? 4 : $urandom_range(1, 4)) @(negedge clk_in);
          sd_byte_available_in = 1'b0;
          repeat ($urandom_range(1, 3)) @(negedge clk_in);
        end
        sd_dout_in = 8'hEE;
        sd_byte_available_in = 1'b1;
        @(negedge clk_in);
        sd_byte_available_in = 1'b0;
        @(negedge clk_in);
        sd_ready_in  = 1'b1;
        model_active = 1'b0;
      end
    end
  end

  // Stream monitor: stream position alone determines the expected indices.
  initial begin
    logic [7:0] exp_byte;
    forever begin
      @(negedge clk_in);
      if (done_out) done_cnt++;
      if (sd_rd_out) rd_cnt++;
      if (data_valid_out) begin
        if (!expect_valid || sb.size() == 0) begin
          check_eq("unexpected_valid", 32'(data_valid_out), 32'd0);
        end else begin
          exp_byte = sb.pop_front();
          check_eq("data", 32'(data_out), 32'(exp_byte));
          check_eq("byte_idx", 32'(byte_index_out), valid_cnt % 512);
          check_eq("sector_idx", 32'(sector_index_out), (valid_cnt / 512) % 65536);
        end
        valid_cnt++;
      end
    end
  end

  task automatic run_transfer(input logic [31:0] start, input logic [15:0] n, input int abort_at);
    int n_eff;
    int cyc;
    bit aborted;
    logic [31:0] exp_addr;
    n_eff = (abort_at >= 0) ? 1 : int'(n);
    got_addr.delete();
    valid_cnt = 0;
    done_cnt  = 0;
    start_sector_in = start;
    num_sectors_in  = n;
    start_in = 1'b1;
    @(negedge clk_in);
    start_in = 1'b0;
    check_eq("busy_after_start", 32'(busy_out), 32'd1);
    check_eq("error_cleared", 32'(error_out), 32'd0);
    aborted = 1'b0;
    cyc = 0;
    while (done_cnt == 0 && cyc < 25000) begin
      @(negedge clk_in);
      cyc++;
      abort_in = 1'b0;
      if (abort_at >= 0 && !aborted && valid_cnt >= abort_at) begin
        abort_in = 1'b1;
        aborted  = 1'b1;
      end
    end
    abort_in = 1'b0;
    cyc = 0;
    while (model_active && cyc < 5000) begin
      @(negedge clk_in);
      cyc++;
    end
    repeat (4) @(negedge clk_in);
    check_eq("done_pulses", 32'(done_cnt), 32'd1);
    check_eq("valid_count", 32'(valid_cnt), 32'(512 * n_eff));
    check_eq("read_count", 32'(got_addr.size()), 32'(n_eff));
    for (int k = 0; k < n_eff && k < got_addr.size(); k++) begin
      exp_addr = (start + 32'(k)) * 32'd512;
      check_eq("sd_addr", got_addr[k], exp_addr);
    end
    check_eq("busy_end", 32'(busy_out), 32'd0);
    check_eq("error_end", 32'(error_out), 32'd0);
    check_eq("rd_end", 32'(sd_rd_out), 32'd0);
    check_eq("sb_drained", 32'(sb.size()), 32'd0);
    sb.delete();
    $display("run start=0x%08h n=%0d abort_at=%0d reads=%0d valids=%0d dones=%0d",
             start, n, abort_at, got_addr.size(), valid_cnt, done_cnt);
  endtask

  initial begin
    int cyc;
    rst_in          = 1'b1;
    start_in        = 1'b0;
    start_sector_in = '0;
    num_sectors_in  = '0;
    abort_in        = 1'b0;
    repeat (3) @(negedge clk_in);
    check_eq("rst_rd", 32'(sd_rd_out), 32'd0);
    check_eq("rst_busy", 32'(busy_out), 32'd0);
    check_eq("rst_done", 32'(done_out), 32'd0);
    check_eq("rst_error", 32'(error_out), 32'd0);
    check_eq("rst_valid", 32'(data_valid_out), 32'd0);
    check_eq("rst_addr", sd_addr_out, 32'd0);
    rst_in = 1'b0;
    @(negedge clk_in);

    run_transfer(32'd5, 16'd2, -1);
    hold4 = 1'b1;
    run_transfer($urandom, 16'd1, -1);
    hold4 = 1'b0;
    run_transfer($urandom, 16'd3, 100);
    for (int r = 0; r < 3; r++) begin
      run_transfer((r == 0) ? 32'hFFFF_FFFF : $urandom, 16'($urandom_range(1, 3)), -1);
    end

    // Zero-length request: done pulse only, no read, never busy.
    got_addr.delete();
    rd_cnt = 0;
    num_sectors_in = 16'd0;
    start_sector_in = $urandom;
    start_in = 1'b1;
    @(negedge clk_in);
    start_in = 1'b0;
    check_eq("zero_done", 32'(done_out), 32'd1);
    check_eq("zero_busy", 32'(busy_out), 32'd0);
    @(negedge clk_in);
    check_eq("zero_done_clear", 32'(done_out), 32'd0);
    repeat (10) @(negedge clk_in);
    check_eq("zero_rd", 32'(rd_cnt), 32'd0);
    $display("run zero-length rd_cycles=%0d", rd_cnt);

    // Ready stuck low: timeout after 50 cycles in WAIT_READY.
    ready_stuck = 1'b1;
    repeat (2) @(negedge clk_in);
    rd_cnt = 0;
    start_sector_in = $urandom;
    num_sectors_in = 16'd2;
    start_in = 1'b1;
    @(negedge clk_in);
    start_in = 1'b0;
    repeat (49) @(negedge clk_in);
    check_eq("to_error_early", 32'(error_out), 32'd0);
    check_eq("to_busy_early", 32'(busy_out), 32'd1);
    @(negedge clk_in);
    check_eq("to_error", 32'(error_out), 32'd1);
    check_eq("to_done", 32'(done_out), 32'd1);
    check_eq("to_rd", 32'(sd_rd_out), 32'd0);
    @(negedge clk_in);
    check_eq("to_done_clear", 32'(done_out), 32'd0);
    check_eq("to_busy_clear", 32'(busy_out), 32'd0);
    check_eq("to_error_sticky", 32'(error_out), 32'd1);
    check_eq("to_no_read", 32'(rd_cnt), 32'd0);
    $display("run timeout error=%0d rd_cycles=%0d", error_out, rd_cnt);
    ready_stuck = 1'b0;
    @(negedge clk_in);
    run_transfer($urandom, 16'd1, -1);

    // Reset in the middle of a sector.
    valid_cnt = 0;
    start_sector_in = $urandom;
    num_sectors_in = 16'd3;
    start_in = 1'b1;
    @(negedge clk_in);
    start_in = 1'b0;
    cyc = 0;
    while (valid_cnt < 200 && cyc < 5000) begin
      @(negedge clk_in);
      cyc++;
    end
    check_eq("mid_reset_reached", 32'(valid_cnt >= 200), 32'd1);
    rst_in = 1'b1;
    @(posedge clk_in);
    expect_valid = 1'b0;
    #1;
    check_eq("mr_valid", 32'(data_valid_out), 32'd0);
    check_eq("mr_rd", 32'(sd_rd_out), 32'd0);
    check_eq("mr_busy", 32'(busy_out), 32'd0);
    check_eq("mr_done", 32'(done_out), 32'd0);
    check_eq("mr_error", 32'(error_out), 32'd0);
    check_eq("mr_addr", sd_addr_out, 32'd0);
    check_eq("mr_data", 32'(data_out), 32'd0);
    check_eq("mr_byte_idx", 32'(byte_index_out), 32'd0);
    check_eq("mr_sector_idx", 32'(sector_index_out), 32'd0);
    @(negedge clk_in);
    rst_in = 1'b0;
    cyc = 0;
    while (model_active && cyc < 5000) begin
      @(negedge clk_in);
      cyc++;
    end
    repeat (10) @(negedge clk_in);
    check_eq("mr_idle_busy", 32'(busy_out), 32'd0);
    check_eq("mr_idle_rd", 32'(sd_rd_out), 32'd0);
    sb.delete();
    expect_valid = 1'b1;
    $display("run mid-sector reset valids_before=%0d", valid_cnt);

    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
